// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader: FSM state encoding,
// frame-field widths and small state-classification helpers.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } ld_state_e;

  localparam int         DEF_ADDR_W      = 11;
  localparam int         DEF_DEPTH       = 2048;
  localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;
  localparam int         DEF_TIMEOUT_CYC = 2_700_000;

  localparam int CNT_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  // The byte input is closed only while a word is being written or a frame is finishing.
  function automatic logic rx_open(input ld_state_e s);
    return !(s inside {ST_WRITE, ST_DONE, ST_ERR});
  endfunction

  function automatic logic timer_active(input ld_state_e s);
    return (s inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM});
  endfunction

endpackage

// File: rtl/imem_ld_timeout.sv
// Idle-cycle counter for the loader: cleared on demand, counts while enabled and
// saturates at LIMIT, where it reports expiry.
module imem_ld_timeout #(
  parameter int LIMIT = 2_700_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign expired = (count_q == W'(LIMIT));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction BSRAM: assembles little-endian words from a framed
// UART byte stream, writes them sequentially and checks the XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W      = DEF_ADDR_W,
  parameter int         DEPTH       = DEF_DEPTH,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  // One extra address bit so a full-depth frame can be compared against CNT.
  localparam int AW1 = ADDR_W + 1;

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW1-1:0]    addr_q, addr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  logic              rx_ready_q, rx_ready_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0] mem_ad_q, mem_ad_d;
  logic [WORD_W-1:0] mem_din_q, mem_din_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              byte_acc;
  logic              timed_out;
  logic [CNT_W-1:0]  cnt_full;
  logic [AW1-1:0]    addr_inc;
  logic [WORD_W-1:0] word_next;

  assign byte_acc  = rx_valid && rx_ready_q;
  assign cnt_full  = {rx_data, cnt_q[7:0]};
  assign addr_inc  = addr_q + AW1'(1);

  imem_ld_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (byte_acc || !timer_active(state_q)),
    .enable  (timer_active(state_q)),
    .expired (timed_out)
  );

  always_comb begin
    word_next = word_q;
    word_next[{byte_idx_q, 3'b000} +: 8] = rx_data;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    csum_d      = csum_q;
    mem_ad_d    = mem_ad_q;
    mem_din_d   = mem_din_q;
    load_err_d  = load_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (byte_acc && rx_data == SYNC_BYTE) begin
          state_d    = ST_LEN0;
          csum_d     = '0;
          load_err_d = 1'b0;
        end
      end
      ST_LEN0: begin
        if (byte_acc) begin
          cnt_d[7:0] = rx_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (byte_acc) begin
          cnt_d = cnt_full;
          if (cnt_full > CNT_W'(DEPTH)) begin
            state_d = ST_ERR;
          end else if (cnt_full == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d    = ST_DATA;
            addr_d     = '0;
            byte_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (byte_acc) begin
          word_d     = word_next;
          csum_d     = csum_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d   = ST_WRITE;
            mem_ad_d  = addr_q[ADDR_W-1:0];
            mem_din_d = word_next;
          end
        end
      end
      ST_WRITE: begin
        addr_d  = addr_inc;
        state_d = (CNT_W'(addr_inc) == cnt_q) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (byte_acc) begin
          state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A stalled sender abandons the frame; a byte arriving on the same cycle still wins.
    if (timed_out && !byte_acc && timer_active(state_q)) begin
      state_d = ST_ERR;
    end

    rx_ready_d  = rx_open(state_d);
    wr_pulse_d  = (state_d == ST_WRITE);
    cpu_hold_d  = (state_d != ST_IDLE);
    load_done_d = (state_d == ST_DONE);
    if (state_d == ST_ERR) begin
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      rx_ready_q  <= 1'b1;
      wr_pulse_q  <= 1'b0;
      mem_ad_q    <= '0;
      mem_din_q   <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      rx_ready_q  <= rx_ready_d;
      wr_pulse_q  <= wr_pulse_d;
      mem_ad_q    <= mem_ad_d;
      mem_din_q   <= mem_din_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_ce    = wr_pulse_q;
  assign mem_wre   = wr_pulse_q;
  assign mem_ad    = mem_ad_q;
  assign mem_din   = mem_din_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven frames plus hand-written sequences for
// write latency, timeout, full-depth load and asynchronous reset mid-frame.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_ce;
  logic        mem_wre;
  logic [10:0] mem_ad;
  logic [31:0] mem_din;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  imem_loader #(
    .ADDR_W      (11),
    .DEPTH       (2048),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_ce    (mem_ce),
    .mem_wre   (mem_wre),
    .mem_ad    (mem_ad),
    .mem_din   (mem_din),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Write/done monitor, sampled on the falling edge away from the register updates.
  int          wr_count   = 0;
  int          done_count = 0;
  logic [10:0] wr_ad  [4096];
  logic [31:0] wr_din [4096];
  logic        wr_ce  [4096];

  always @(negedge clk) begin
    if (mem_wre) begin
      if (wr_count < 4096) begin
        wr_ad[wr_count]  <= mem_ad;
        wr_din[wr_count] <= mem_din;
        wr_ce[wr_count]  <= mem_ce;
      end
      wr_count <= wr_count + 1;
    end
    if (load_done) begin
      done_count <= done_count + 1;
    end
  end

  typedef struct {
    string       name;
    int          nbytes;
    logic [127:0] frame;
    int          exp_wr;
    int          exp_done;
    logic        exp_err;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t        vecs [5];
  logic [7:0]  fb;
  logic [31:0] word_v;
  logic [7:0]  csum_m;
  int          wr_base;
  int          done_base;
  int          idle;
  int          seq_bad;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Present one byte at a falling edge and hold it until the loader accepts it.
  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    guard    = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL rx_ready_wait: got 0 want 1 for byte %0h", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"happy", 12,
                {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C, 32'h0},
                2, 1, 1'b0, 32'h0000_0013, 32'h0000_006F};
    vecs[1] = '{"badsum", 12,
                {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D, 32'h0},
                2, 0, 1'b1, 32'h0000_0013, 32'h0000_006F};
    vecs[2] = '{"oversize", 3,
                {8'hA5, 8'h01, 8'h08, 104'h0},
                0, 0, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{"zero_junk", 6,
                {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 80'h0},
                0, 1, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{"byteorder", 8,
                {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22, 64'h0},
                1, 1, 1'b0, 32'hDEAD_BEEF, 32'h0};

    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_rx_ready", rx_ready, 1);
    checkOutput("rst_mem_ce", mem_ce, 0);
    checkOutput("rst_mem_wre", mem_wre, 0);
    checkOutput("rst_mem_ad", mem_ad, 0);
    checkOutput("rst_mem_din", mem_din, 0);
    checkOutput("rst_cpu_hold", cpu_hold, 0);
    checkOutput("rst_load_done", load_done, 0);
    checkOutput("rst_load_err", load_err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      wr_base   = wr_count;
      done_base = done_count;
      for (int k = 0; k < vecs[v].nbytes; k++) begin
        fb = vecs[v].frame[127-8*k -: 8];
        applyStimulus(fb);
      end
      repeat (4) @(negedge clk);
      checkOutput({vecs[v].name, "_writes"}, wr_count - wr_base, vecs[v].exp_wr);
      checkOutput({vecs[v].name, "_done"}, done_count - done_base, vecs[v].exp_done);
      checkOutput({vecs[v].name, "_err"}, load_err, vecs[v].exp_err);
      checkOutput({vecs[v].name, "_hold"}, cpu_hold, 0);
      checkOutput({vecs[v].name, "_ready"}, rx_ready, 1);
      if (vecs[v].exp_wr >= 1) begin
        checkOutput({vecs[v].name, "_ad0"}, wr_ad[wr_base], 0);
        checkOutput({vecs[v].name, "_w0"}, wr_din[wr_base], vecs[v].exp_w0);
        checkOutput({vecs[v].name, "_ce0"}, wr_ce[wr_base], 1);
      end
      if (vecs[v].exp_wr >= 2) begin
        checkOutput({vecs[v].name, "_ad1"}, wr_ad[wr_base+1], 1);
        checkOutput({vecs[v].name, "_w1"}, wr_din[wr_base+1], vecs[v].exp_w1);
      end
    end

    // Write latency: the cycle after the 4th byte is accepted is the write cycle.
    done_base = done_count;
    applyStimulus(8'hA5);
    checkOutput("lat_hold_after_sync", cpu_hold, 1);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    checkOutput("lat_wre", mem_wre, 1);
    checkOutput("lat_ce", mem_ce, 1);
    checkOutput("lat_ready_low", rx_ready, 0);
    checkOutput("lat_ad", mem_ad, 0);
    checkOutput("lat_din", mem_din, 32'h4433_2211);
    @(negedge clk);
    checkOutput("lat_wre_drop", mem_wre, 0);
    checkOutput("lat_ce_drop", mem_ce, 0);
    checkOutput("lat_din_held", mem_din, 32'h4433_2211);
    applyStimulus(8'h44);
    checkOutput("lat_done_pulse", load_done, 1);
    checkOutput("lat_hold_in_done", cpu_hold, 1);
    @(negedge clk);
    checkOutput("lat_done_drop", load_done, 0);
    checkOutput("lat_hold_drop", cpu_hold, 0);
    checkOutput("lat_done_count", done_count - done_base, 1);

    // Timeout: stop after 2 of 4 data bytes and let the idle counter expire.
    applyStimulus(8'hA5);
    applyStimulus(8'h04);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (50) @(negedge clk);
    idle = 50;
    checkOutput("to_no_err_early", load_err, 0);
    checkOutput("to_hold_early", cpu_hold, 1);
    while (!load_err && idle < 300) begin
      @(negedge clk);
      idle++;
    end
    checkOutput("to_err", load_err, 1);
    checkOutput("to_window", (idle >= 95 && idle <= 110), 1);
    @(negedge clk);
    checkOutput("to_hold_drop", cpu_hold, 0);

    wr_base   = wr_count;
    done_base = done_count;
    applyStimulus(8'hA5);
    checkOutput("to_err_cleared", load_err, 0);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h78);
    applyStimulus(8'h56);
    applyStimulus(8'h34);
    applyStimulus(8'h12);
    applyStimulus(8'h08);
    repeat (3) @(negedge clk);
    checkOutput("to_next_writes", wr_count - wr_base, 1);
    checkOutput("to_next_w0", wr_din[wr_base], 32'h1234_5678);
    checkOutput("to_next_ad0", wr_ad[wr_base], 0);
    checkOutput("to_next_done", done_count - done_base, 1);
    checkOutput("to_next_err", load_err, 0);

    // Full depth: 2048 words, address 2047 written last.
    wr_base   = wr_count;
    done_base = done_count;
    csum_m    = 8'h00;
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h08);
    for (int i = 0; i < 2048; i++) begin
      word_v = {16'hC0DE, 16'(i)};
      for (int b = 0; b < 4; b++) begin
        fb     = word_v[8*b +: 8];
        csum_m = csum_m ^ fb;
        applyStimulus(fb);
      end
    end
    applyStimulus(csum_m);
    repeat (3) @(negedge clk);
    checkOutput("full_writes", wr_count - wr_base, 2048);
    checkOutput("full_last_ad", wr_ad[wr_base+2047], 11'd2047);
    checkOutput("full_last_din", wr_din[wr_base+2047], 32'hC0DE_07FF);
    seq_bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (wr_ad[wr_base+i] !== 11'(i) || wr_din[wr_base+i] !== {16'hC0DE, 16'(i)}) begin
        seq_bad++;
      end
    end
    checkOutput("full_sequence", seq_bad, 0);
    checkOutput("full_done", done_count - done_base, 1);
    checkOutput("full_err", load_err, 0);

    // Asynchronous reset in the middle of the third word.
    applyStimulus(8'hA5);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(8'(8'h10 + i));
    end
    @(negedge clk);
    checkOutput("rmid_ad_before", mem_ad, 1);
    checkOutput("rmid_hold_before", cpu_hold, 1);
    wr_base  = wr_count;
    rx_data  = 8'h1B;
    rx_valid = 1'b1;
    reset    = 1'b1;
    #1;
    checkOutput("rmid_hold", cpu_hold, 0);
    checkOutput("rmid_ready", rx_ready, 1);
    checkOutput("rmid_wre", mem_wre, 0);
    checkOutput("rmid_ce", mem_ce, 0);
    checkOutput("rmid_ad", mem_ad, 0);
    checkOutput("rmid_din", mem_din, 0);
    checkOutput("rmid_err", load_err, 0);
    @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rmid_no_write", wr_count - wr_base, 0);
    checkOutput("rmid_hold_after", cpu_hold, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
